// File: rtl/veda_pkg.sv
// Shared definitions for the veda data-memory arbiter and the memory it fronts.
package veda_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DEPTH      = 32;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SCRUB = 1'b1
  } state_t;

endpackage

// File: rtl/veda_if.sv
// Requester, scrub-control and memory-side signals of the veda arbiter.
interface veda_if #(
  parameter int DATA_WIDTH = veda_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = veda_pkg::DEF_ADDR_WIDTH
);

  logic                  r0_req;
  logic                  r0_we;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic                  r0_gnt;
  logic                  r0_rvalid;
  logic [DATA_WIDTH-1:0] r0_rdata;

  logic                  r1_req;
  logic                  r1_we;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic                  r1_gnt;
  logic                  r1_rvalid;
  logic [DATA_WIDTH-1:0] r1_rdata;

  logic                  scrub_start;
  logic                  scrub_busy;
  logic                  scrub_done;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    input  scrub_start,
    output scrub_busy, scrub_done,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters and memory side.
  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    output scrub_start,
    input  scrub_busy, scrub_done,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/veda_rr_arb2.sv
// Two-input round-robin grant with a last-winner register; on contention the
// input that did not win last time is granted.
module veda_rr_arb2
  import veda_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant_r;

  // Combinational grant selection.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant_r == REQ0) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Remember the winner of every granted cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_r <= REQ1;
    end else if (gnt[0]) begin
      last_grant_r <= REQ0;
    end else if (gnt[1]) begin
      last_grant_r <= REQ1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/veda_arbiter.sv
// Shares the single-port data memory between two requesters and runs a
// whole-memory zero-fill scrub on command.
module veda_arbiter
  import veda_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input logic   clk,
  input logic   rst,
  veda_if.slave bus
);

  // One extra counter bit lets DEPTH == 2**ADDR_WIDTH finish without wrapping.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH:0]   cnt_r;
  logic                  cnt_last_s;
  logic [1:0]            gnt_s;
  logic                  drive_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [ADDR_WIDTH-1:0] addr_hold_r;
  logic [DATA_WIDTH-1:0] wdata_hold_r;
  logic [1:0]            rvalid_r;
  logic [DATA_WIDTH-1:0] rdata0_r;
  logic [DATA_WIDTH-1:0] rdata1_r;
  logic                  done_r;

  assign cnt_last_s = (cnt_r == CNT_LAST);

  veda_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (state_r == ST_IDLE),
    .req ({bus.r1_req, bus.r0_req}),
    .gnt (gnt_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; scrub_start is only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = bus.scrub_start ? ST_SCRUB : ST_IDLE;
      ST_SCRUB: state_nxt_s = cnt_last_s ? ST_IDLE : ST_SCRUB;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Memory drive: granted requester in IDLE, counter in SCRUB, else hold.
  always_comb begin
    drive_s     = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = addr_hold_r;
    mem_wdata_s = wdata_hold_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_s[0]) begin
          drive_s     = 1'b1;
          mem_we_s    = bus.r0_we;
          mem_addr_s  = bus.r0_addr;
          mem_wdata_s = bus.r0_wdata;
        end else if (gnt_s[1]) begin
          drive_s     = 1'b1;
          mem_we_s    = bus.r1_we;
          mem_addr_s  = bus.r1_addr;
          mem_wdata_s = bus.r1_wdata;
        end else begin
          drive_s     = 1'b0;
        end
      end
      ST_SCRUB: begin
        drive_s     = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = cnt_r[ADDR_WIDTH-1:0];
        mem_wdata_s = {DATA_WIDTH{1'b0}};
      end
      default: begin
        drive_s     = 1'b0;
      end
    endcase
  end

  // Scrub address counter, parked at zero outside SCRUB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {(ADDR_WIDTH + 1){1'b0}};
    end else if (state_r == ST_SCRUB && !cnt_last_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= {(ADDR_WIDTH + 1){1'b0}};
    end
  end

  // Last driven address/data, presented while the memory is idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_hold_r  <= {ADDR_WIDTH{1'b0}};
      wdata_hold_r <= {DATA_WIDTH{1'b0}};
    end else if (drive_s) begin
      addr_hold_r  <= mem_addr_s;
      wdata_hold_r <= mem_wdata_s;
    end else begin
      addr_hold_r  <= addr_hold_r;
      wdata_hold_r <= wdata_hold_r;
    end
  end

  // Read return path and the scrub completion pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_r <= 2'b00;
      rdata0_r <= {DATA_WIDTH{1'b0}};
      rdata1_r <= {DATA_WIDTH{1'b0}};
      done_r   <= 1'b0;
    end else begin
      rvalid_r <= {gnt_s[1] & ~bus.r1_we, gnt_s[0] & ~bus.r0_we};
      rdata0_r <= (gnt_s[0] && !bus.r0_we) ? bus.mem_rdata : rdata0_r;
      rdata1_r <= (gnt_s[1] && !bus.r1_we) ? bus.mem_rdata : rdata1_r;
      done_r   <= (state_r == ST_SCRUB) && cnt_last_s;
    end
  end

  assign bus.r0_gnt     = gnt_s[0];
  assign bus.r1_gnt     = gnt_s[1];
  assign bus.r0_rvalid  = rvalid_r[0];
  assign bus.r1_rvalid  = rvalid_r[1];
  assign bus.r0_rdata   = rdata0_r;
  assign bus.r1_rdata   = rdata1_r;
  assign bus.scrub_busy = (state_r == ST_SCRUB);
  assign bus.scrub_done = done_r;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;

endmodule

// File: tb/tb_veda_arbiter.sv
// Randomised and directed bench for veda_arbiter: a transaction-level model
// predicts grants, memory drive and scrub progress; read data goes via queues.
module tb_veda_arbiter;
  import veda_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct packed {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  veda_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  veda_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment memory: combinational read, write at the edge.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH];
  int            last_win   = 1;
  int            scrub_left = 0;
  bit            done_exp   = 1'b0;
  logic [AW-1:0] last_addr  = '0;
  logic [DW-1:0] last_wdata = '0;
  bit            pend [2];
  cmd_t          cmd  [2];
  rd_t           q0 [$];
  rd_t           q1 [$];

  int n_cmp  = 0;
  int n_err  = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic post(input int r, input bit we, input int addr, input logic [DW-1:0] data);
    pend[r]      = 1'b1;
    cmd[r].we    = we;
    cmd[r].addr  = AW'(addr);
    cmd[r].data  = data;
  endtask

  // One clock cycle: drive, predict, compare, then advance the model.
  task automatic step(input logic rst_v, input logic scrub_v);
    logic [1:0] exp_g;
    int         g;
    int         a;
    rd_t        e;
    bit         done_nxt;
    @(negedge clk);
    rst             = rst_v;
    bus.scrub_start = scrub_v;
    bus.r0_req = pend[0]; bus.r0_we = cmd[0].we; bus.r0_addr = cmd[0].addr; bus.r0_wdata = cmd[0].data;
    bus.r1_req = pend[1]; bus.r1_we = cmd[1].we; bus.r1_addr = cmd[1].addr; bus.r1_wdata = cmd[1].data;
    #1;
    exp_g = 2'b00;
    if (scrub_left == 0) begin
      if (pend[0] && pend[1]) exp_g = (last_win == 0) ? 2'b10 : 2'b01;
      else                    exp_g = {pend[1], pend[0]};
    end
    chk("r0_gnt", bus.r0_gnt, exp_g[0]);
    chk("r1_gnt", bus.r1_gnt, exp_g[1]);
    chk("scrub_busy", bus.scrub_busy, scrub_left > 0);
    chk("scrub_done", bus.scrub_done, done_exp);
    if (scrub_left > 0) begin
      a = DEPTH - scrub_left;
      chk("scrub_mem_we", bus.mem_we, 1);
      chk("scrub_mem_addr", bus.mem_addr, a);
      chk("scrub_mem_wdata", bus.mem_wdata, 0);
      ref_mem[a] = '0;
      last_addr  = AW'(a);
      last_wdata = '0;
    end else if (exp_g != 2'b00) begin
      g = exp_g[1] ? 1 : 0;
      chk("mem_we", bus.mem_we, cmd[g].we);
      chk("mem_addr", bus.mem_addr, cmd[g].addr);
      chk("mem_wdata", bus.mem_wdata, cmd[g].data);
      if (cmd[g].we) begin
        ref_mem[cmd[g].addr] = cmd[g].data;
      end else begin
        e.due  = cyc + 1;
        e.data = ref_mem[cmd[g].addr];
        if (g == 0) q0.push_back(e); else q1.push_back(e);
      end
      last_win   = g;
      last_addr  = cmd[g].addr;
      last_wdata = cmd[g].data;
    end else begin
      chk("idle_mem_we", bus.mem_we, 0);
      chk("idle_mem_addr", bus.mem_addr, last_addr);
      chk("idle_mem_wdata", bus.mem_wdata, last_wdata);
    end
    if (bus.r0_gnt === 1'b1) pend[0] = 1'b0;
    if (bus.r1_gnt === 1'b1) pend[1] = 1'b0;
    done_nxt = 1'b0;
    if (scrub_left > 0) begin
      scrub_left--;
      if (scrub_left == 0) done_nxt = 1'b1;
    end else if (scrub_v) begin
      scrub_left = DEPTH;
    end
    done_exp = done_nxt;
    if (!rst_v) begin
      scrub_left = 0; done_exp = 1'b0; last_win = 1;
      last_addr = '0; last_wdata = '0;
      pend[0] = 1'b0; pend[1] = 1'b0;
      q0.delete(); q1.delete();
    end
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    while ((pend[0] || pend[1]) && n < max) begin
      step(1'b1, 1'b0);
      n++;
    end
    if (pend[0] || pend[1]) begin
      n_cmp++; n_err++;
      $display("FAIL grant_timeout: requests still pending after %0d cycles", max);
      pend[0] = 1'b0; pend[1] = 1'b0;
    end
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) begin
      post(1, 1'b1, i, $urandom | 32'h1);
      run_until_idle(4);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_r0_rvalid", bus.r0_rvalid, 0);
    chk("rst_r1_rvalid", bus.r1_rvalid, 0);
    chk("rst_r0_rdata", bus.r0_rdata, 0);
    chk("rst_r1_rdata", bus.r1_rdata, 0);
  endtask

  // Read-return monitor: each expected read must appear exactly when due.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
        chk("r0_rvalid", bus.r0_rvalid, 1);
        chk("r0_rdata", bus.r0_rdata, q0[0].data);
        void'(q0.pop_front());
      end else if (bus.r0_rvalid !== 1'b0) begin
        n_cmp++; n_err++;
        $display("FAIL r0_rvalid_spurious: got %b expected 0 (cycle %0d)", bus.r0_rvalid, cyc);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        chk("r1_rvalid", bus.r1_rvalid, 1);
        chk("r1_rdata", bus.r1_rdata, q1[0].data);
        void'(q1.pop_front());
      end else if (bus.r1_rvalid !== 1'b0) begin
        n_cmp++; n_err++;
        $display("FAIL r1_rvalid_spurious: got %b expected 0 (cycle %0d)", bus.r1_rvalid, cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    cmd[0] = '0; cmd[1] = '0;
    bus.scrub_start = 1'b0;
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;

    step(1'b1, 1'b0);
    chk_reset_outputs();

    // Write then read back on requester 0.
    post(0, 1'b1, 3, 32'h0000_00AA); run_until_idle(4);
    post(0, 1'b0, 3, 32'h0);         run_until_idle(4);
    step(1'b1, 1'b0);

    // Write on r1, read of the same address on r0 in the very next cycle.
    post(1, 1'b1, 7, 32'h0000_1234); step(1'b1, 1'b0);
    post(0, 1'b0, 7, 32'h0);         step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    preload();

    // Both requesters reading back to back: grants must alternate.
    for (int i = 0; i < 4; i++) begin
      if (!pend[0]) post(0, 1'b0, $urandom_range(0, DEPTH - 1), 32'h0);
      if (!pend[1]) post(1, 1'b0, $urandom_range(0, DEPTH - 1), 32'h0);
      step(1'b1, 1'b0);
    end
    run_until_idle(4);

    // Random mixed traffic with occasional scrubs.
    for (int i = 0; i < 300; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 99) < 60)
          post(r, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom);
      step(1'b1, 1'($urandom_range(0, 79) == 0));
    end
    run_until_idle(40);
    while (scrub_left > 0 || done_exp) step(1'b1, 1'b0);

    // Full scrub with r0 held waiting throughout.
    preload();
    step(1'b1, 1'b1);
    post(0, 1'b0, 15, 32'h0);
    run_until_idle(40);
    post(0, 1'b0, 0, 32'h0);  run_until_idle(4);
    post(0, 1'b0, 31, 32'h0); run_until_idle(4);
    step(1'b1, 1'b0);

    // scrub_start repeated mid-scrub must not restart it.
    step(1'b1, 1'b1);
    for (int i = 0; i < 36; i++) step(1'b1, 1'(i == 5 || i == 20 || i == 30));

    // Reset in the middle of a scrub aborts it.
    preload();
    post(1, 1'b0, 9, 32'h0); run_until_idle(4);
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk_reset_outputs();
    post(0, 1'b0, 5, 32'h0);  run_until_idle(4);
    post(0, 1'b0, 20, 32'h0); run_until_idle(4);
    repeat (3) step(1'b1, 1'b0);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/veda_arbiter.md
Name: veda_arbiter

Overview:
- Two-port round-robin arbiter and scrub sequencer in front of the single-port data memory.
- Shares the memory between requester 0 (core load/store path) and requester 1 (debug/loader port).
- Owns all memory write-enable, address and write-data drive; at most one memory access per cycle.
- Built-in scrub FSM zero-fills the whole memory on command, replacing bulk clears done inside the memory.

Parameters:
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 5, memory address width.
- DEPTH, 32, number of words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- r0_req  in  1  requester 0 access request.
- r0_we  in  1  1 = write, 0 = read.
- r0_addr  in  ADDR_WIDTH  word address.
- r0_wdata  in  DATA_WIDTH  write data.
- r0_gnt  out  1  access performed this cycle.
- r0_rvalid  out  1  read data valid, one-cycle pulse.
- r0_rdata  out  DATA_WIDTH  read data.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as requester 0, for requester 1.
- scrub_start  in  1  start zero-fill of the whole memory.
- scrub_busy  out  1  scrub in progress.
- scrub_done  out  1  one-cycle pulse when scrub completes.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, combinational from mem_addr.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE; scrub counter cleared to 0.
  - last_grant set to 1, so requester 0 wins the first contention.
  - All outputs are 0: gnt, rvalid, rdata, scrub_busy, scrub_done, mem_we, mem_addr, mem_wdata.
- FSM states: IDLE and SCRUB.
- IDLE, grant logic (combinational):
  - Only one request high: that requester is granted.
  - Both high: grant goes to the requester not equal to last_grant.
  - No request: no grant.
  - Granted requester's we/addr/wdata drive mem_* combinationally in the same cycle. No request: mem_we=0, and mem_addr/mem_wdata hold their last values.
  - last_grant updates at the clock edge of every grant.
- Requester hold rule: a requester holds req and its command stable until it sees gnt=1. gnt is that requester's acknowledgement.
- Write latency: a granted write commits at the same clock edge.
- Read latency:
  - A granted read captures mem_rdata into that requester's rdata register at the edge.
  - rvalid pulses for exactly the following cycle.
  - rdata holds its value until the next read for that requester.
- Ordering: a read to an address written in the previous cycle returns the new data.
- IDLE to SCRUB:
  - scrub_start=1 in IDLE moves the FSM to SCRUB at the next edge.
  - A request granted in that same cycle is still serviced normally.
- SCRUB:
  - scrub_busy=1, and both gnt outputs are forced to 0; requests stall.
  - Each cycle: mem_we=1, mem_addr=counter, mem_wdata=0; the counter then increments.
  - After the write to address DEPTH-1: return to IDLE, and scrub_done=1 for the first IDLE cycle.
  - Total scrub length is exactly DEPTH cycles.
  - scrub_start during SCRUB is ignored.
- Reset during SCRUB: aborts immediately to the reset values above. Partial zero-fill is accepted.
- Address width: addresses ≥ DEPTH are passed through unchanged; range checking is the requester's job.
- Counter width: ADDR_WIDTH+1 bits, so DEPTH = 2**ADDR_WIDTH terminates without wrap.

Decomposition:
- Shared package veda_pkg holds:
  - FSM state enum (ST_IDLE, ST_SCRUB).
  - Requester index constants REQ0=0, REQ1=1.
  - Default DATA_WIDTH/ADDR_WIDTH constants shared with the memory.
- One natural sub-module: veda_rr_arb2. It is the two-input round-robin grant logic with a last_grant register, reused later for other shared resources.
- Scrub counter and FSM stay in the top module.

Test Plan:
- Reset, then r0 writes 0x0000_00AA to addr 3, then r0 reads addr 3 → r0_gnt=1 in each request cycle; r0_rvalid=1 one cycle after the read grant with r0_rdata=0xAA.
- r0_req and r1_req held high together for 4 cycles, both reading → grants alternate r0, r1, r0, r1; each rvalid follows its grant by one cycle; never both gnt high.
- r1 writes 0x1234 to addr 7 in cycle N; r0 reads addr 7 in cycle N+1 → r0_rdata=0x1234.
- Preload all 32 words nonzero, pulse scrub_start; hold r0_req high → scrub_busy high for 32 cycles; mem_addr steps 0..31 with mem_we=1 and mem_wdata=0; r0_gnt=0 throughout; scrub_done pulses once; r0 is granted in the first IDLE cycle; reads of addrs 0, 15, 31 return 0.
- Start scrub, assert rst=0 at scrub cycle 10 → next cycle all outputs 0, FSM in IDLE; addr 5 reads 0 and addr 20 keeps its preload value.
- scrub_start asserted while already in SCRUB → no restart; scrub_done pulses exactly once, 32 cycles after the original start.
